// File: rtl/uart_tx_core.sv
// Double-buffered UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to build in the optional even-parity bit.
module uart_tx_core #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_stop_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic [7:0]           data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam logic [DIV_WIDTH-1:0] DivOne = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q;
  logic [7:0]           hold_q;
  logic                 hold_full_q;
  logic                 load_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 stop2_q;
  logic                 second_stop_q;
  logic                 tx_q;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic parity_q;
`else
  logic unused_parity_en;
  assign unused_parity_en = cfg_parity_en_i;
`endif

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 bit_end;
  logic                 stop_done;
  logic                 start_frame;

  always_comb begin
    div_eff     = (cfg_div_i == '0) ? DivOne : cfg_div_i;
    bit_end     = (cnt_q == '0);
    stop_done   = (state_q == StStop) && bit_end && !(stop2_q && !second_stop_q);
    start_frame = hold_full_q && cfg_en_i && ((state_q == StIdle) || stop_done);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      load_q        <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      div_q         <= '0;
      stop2_q       <= 1'b0;
      second_stop_q <= 1'b0;
      tx_q          <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      parity_q      <= 1'b0;
`endif
    end else begin
      // Holding register frees up one edge after its byte moved to the shifter.
      if (load_q) begin
        hold_full_q <= 1'b0;
        load_q      <= 1'b0;
      end else if (data_valid_i && !hold_full_q) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        StIdle: tx_q <= 1'b1;
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            cnt_q     <= div_q - DivOne;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - DivOne;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= div_q - DivOne;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q <= StParity;
                tx_q    <= parity_q;
              end else begin
                state_q       <= StStop;
                tx_q          <= 1'b1;
                second_stop_q <= 1'b0;
              end
`else
              state_q       <= StStop;
              tx_q          <= 1'b1;
              second_stop_q <= 1'b0;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - DivOne;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q       <= StStop;
            cnt_q         <= div_q - DivOne;
            tx_q          <= 1'b1;
            second_stop_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DivOne;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            if (stop2_q && !second_stop_q) begin
              second_stop_q <= 1'b1;
              cnt_q         <= div_q - DivOne;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - DivOne;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase

      // Frame start overrides the per-state updates; config is frozen here.
      if (start_frame) begin
        state_q <= StStart;
        tx_q    <= 1'b0;
        shift_q <= hold_q;
        load_q  <= 1'b1;
        div_q   <= div_eff;
        cnt_q   <= div_eff - DivOne;
        stop2_q <= cfg_stop_bits_i;
`ifdef UART_TX_PARITY_EN
        par_en_q <= cfg_parity_en_i;
        parity_q <= ^hold_q;
`endif
      end
    end
  end

  assign tx_o         = tx_q;
  assign data_ready_o = !hold_full_q;
  assign busy_o       = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core; parity cases follow UART_TX_PARITY_EN.
module tb_uart_tx_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        cfg_stop_bits_i;
  logic        cfg_parity_en_i;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic        tx_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_core #(.DIV_WIDTH(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_stop_bits_i (cfg_stop_bits_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .data_i          (data_i),
    .data_valid_i    (data_valid_i),
    .data_ready_o    (data_ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected line waveform, one bit per clock, index 0 = first start-bit cycle.
  function automatic void build_frame(input logic [7:0] d, input int div, input bit par,
                                      input bit stop2, output logic [255:0] v,
                                      output int len);
    int dv;
    dv  = (div == 0) ? 1 : div;
    v   = '1;
    len = 0;
    for (int k = 0; k < dv; k++) begin v[len] = 1'b0; len++; end
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < dv; k++) begin v[len] = d[b]; len++; end
    if (par)
      for (int k = 0; k < dv; k++) begin v[len] = ^d; len++; end
    for (int k = 0; k < (stop2 ? 2 : 1) * dv; k++) begin v[len] = 1'b1; len++; end
  endfunction

  task automatic capture(input int n, output logic [255:0] v);
    v = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      v[i] = tx_o;
    end
  endtask

  // Offers a byte and returns at the negedge after the accepting edge.
  task automatic accept_byte(input logic [7:0] d);
    int waited;
    waited       = 0;
    data_i       = d;
    data_valid_i = 1'b1;
    while (!data_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    n_checks++;
    if (waited >= 200) begin
      n_fail++;
      $display("FAIL accept_timeout: data_ready_o=%b after %0d cycles, required 1", data_ready_o,
               waited);
    end
    @(negedge clk_i);
    data_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i           = 1'b1;
    cfg_en_i        = 1'b1;
    cfg_div_i       = 16'd4;
    cfg_stop_bits_i = 1'b0;
    cfg_parity_en_i = 1'b0;
    data_i          = 8'hEE;
    data_valid_i    = 1'b1;
    #3;
    n_checks++;
    if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (data_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready_o);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    data_valid_i = 1'b0;
    rst_i        = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: tx=%b busy=%b want tx=1 busy=0", tx_o, busy_o);
    end
  endtask

  task automatic test_basic;
    logic [255:0] got, exp;
    int len;
    cfg_div_i = 16'd4;
    accept_byte(8'h55);
    n_checks++;
    if (tx_o !== 1'b1 || data_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: tx=%b ready=%b busy=%b want tx=1 ready=0 busy=1", tx_o,
               data_ready_o, busy_o);
    end
    build_frame(8'h55, 4, 1'b0, 1'b0, exp, len);
    capture(40, got);
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL basic_frame_55: got %h want %h", got, exp);
    end
    @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || data_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_end: tx=%b busy=%b ready=%b want 1 0 1", tx_o, busy_o, data_ready_o);
    end
  endtask

  task automatic test_parity;
    logic [255:0] got, exp;
    int len;
    cfg_div_i       = 16'd3;
    cfg_parity_en_i = 1'b1;
`ifdef UART_TX_PARITY_EN
    accept_byte(8'h07);
    build_frame(8'h07, 3, 1'b1, 1'b0, exp, len);
    capture(34, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL parity_frame_07: got %h want %h", got, exp); end
    n_checks++;
    if (got[27] !== 1'b1) begin n_fail++; $display("FAIL parity_bit_07: got %b want 1", got[27]); end
    accept_byte(8'h03);
    build_frame(8'h03, 3, 1'b1, 1'b0, exp, len);
    capture(34, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL parity_frame_03: got %h want %h", got, exp); end
    n_checks++;
    if (got[27] !== 1'b0) begin n_fail++; $display("FAIL parity_bit_03: got %b want 0", got[27]); end
`else
    // Parity request must be ignored: 30-cycle frame followed by idle line.
    accept_byte(8'h07);
    build_frame(8'h07, 3, 1'b0, 1'b0, exp, len);
    capture(34, got);
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL noparity_frame_07: got %h want %h", got, exp);
    end
`endif
    cfg_parity_en_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    logic [255:0] got, exp, e1, e2;
    logic [63:0]  rdy;
    int l1, l2;
    bit pending;
    cfg_div_i       = 16'd2;
    cfg_stop_bits_i = 1'b1;
    build_frame(8'hA5, 2, 1'b0, 1'b1, e1, l1);
    build_frame(8'h3C, 2, 1'b0, 1'b1, e2, l2);
    exp = '1;
    for (int i = 0; i < l1; i++) exp[2 + i] = e1[i];
    for (int i = 0; i < l2; i++) exp[2 + l1 + i] = e2[i];
    got     = '1;
    rdy     = '0;
    pending = 1'b0;
    data_i       = 8'hA5;
    data_valid_i = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk_i);
      got[c] = tx_o;
      rdy[c] = data_ready_o;
      if (c == 1) data_i = 8'h3C;
      if (pending) begin
        data_valid_i = 1'b0;
        pending      = 1'b0;
      end else if (c >= 2 && data_valid_i && data_ready_o) begin
        pending = 1'b1;
      end
    end
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL b2b_frames: got %h want %h", got, exp); end
    n_checks++;
    if (rdy[2] !== 1'b0 || rdy[3] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_first: got %b%b want 01", rdy[2], rdy[3]);
    end
    n_checks++;
    if (rdy[24] !== 1'b0 || rdy[25] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_second: got %b%b want 01", rdy[24], rdy[25]);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy_o); end
    cfg_stop_bits_i = 1'b0;
  endtask

  task automatic test_div0;
    logic [255:0] got, exp;
    int len;
    build_frame(8'hC3, 1, 1'b0, 1'b0, exp, len);
    cfg_div_i = 16'd0;
    accept_byte(8'hC3);
    capture(12, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL div0_frame: got %h want %h", got, exp); end
    cfg_div_i = 16'd1;
    accept_byte(8'hC3);
    capture(12, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL div1_frame: got %h want %h", got, exp); end
  endtask

  task automatic test_enable_gate;
    logic [255:0] got, exp;
    int len;
    bit saw_low;
    cfg_div_i = 16'd2;
    cfg_en_i  = 1'b0;
    accept_byte(8'h81);
    n_checks++;
    if (data_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_accept: ready=%b busy=%b want ready=0 busy=1", data_ready_o, busy_o);
    end
    saw_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) saw_low = 1'b1;
    end
    n_checks++;
    if (saw_low) begin n_fail++; $display("FAIL gate_tx_idle: tx went low, want stay 1"); end
    cfg_en_i = 1'b1;
    build_frame(8'h81, 2, 1'b0, 1'b0, exp, len);
    capture(22, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL gate_frame_81: got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    int waited;
    cfg_div_i = 16'd4;
    accept_byte(8'h5A);
    data_i       = 8'hFF;
    data_valid_i = 1'b1;
    waited       = 1;
    while (!data_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    @(negedge clk_i);
    data_valid_i = 1'b0;
    waited++;
    n_checks++;
    if (data_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_held: ready=%b want 0", data_ready_o);
    end
    // Advance to the second cycle of data bit 2 (sample N15), which is 0 for 0x5A.
    while (waited < 15) begin
      @(negedge clk_i);
      waited++;
    end
    n_checks++;
    if (tx_o !== 1'b0) begin n_fail++; $display("FAIL midrst_bit2: got %b want 0", tx_o); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || data_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: tx=%b ready=%b busy=%b want 1 1 0", tx_o, data_ready_o,
               busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    bad   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midrst_no_frame: activity after reset release"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_div0();
    test_enable_gate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, the width of the baud divisor.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port cfg_en_i, input, 1, transmitter enable.
REQ-005 SHALL have port cfg_div_i, input, DIV_WIDTH, clock cycles per bit.
REQ-006 SHALL have port cfg_stop_bits_i, input, 1: 0 means one stop bit; 1 means two stop bits.
REQ-007 SHALL have port cfg_parity_en_i, input, 1, even-parity enable.
REQ-008 SHALL have port data_i, input, 8, byte to send.
REQ-009 SHALL have port data_valid_i, input, 1, byte offered.
REQ-010 SHALL have port data_ready_o, output, 1, holding register empty.
REQ-011 SHALL have port tx_o, output, 1, serial line, idle high.
REQ-012 SHALL have port busy_o, output, 1, high while a frame or a held byte is pending.

Function
REQ-013 SHALL transfer a byte when data_valid_i and data_ready_o are both high at a rising edge; data_ready_o SHALL depend only on registered state.
REQ-014 SHALL double-buffer the data path: a holding register (data_ready_o = empty) feeds a shift register, so one byte can be accepted while another is shifting.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-016 IDLE SHALL go to START on the edge after the holding register becomes full with cfg_en_i high; tx_o SHALL go low exactly 1 cycle after acceptance in IDLE.
REQ-017 START SHALL go to DATA; DATA SHALL go to PARITY if parity is enabled, else to STOP; PARITY SHALL go to STOP; STOP SHALL go to START if the holding register is full and cfg_en_i is high, else to IDLE.
REQ-018 Each bit SHALL last exactly max(cfg_div_i,1) cycles, counted by a DIV_WIDTH down-counter; cfg_div_i, cfg_stop_bits_i and cfg_parity_en_i SHALL be latched at entry to START and held for the whole frame.
REQ-019 Data SHALL be sent LSB first, 8 bits; the parity bit SHALL be the XOR of the 8 data bits (even parity); stop bits SHALL drive 1.
REQ-020 Back-to-back frames SHALL have zero idle cycles between the last stop bit and the next start bit.
REQ-021 The holding register SHALL move to the shift register at entry to START, and data_ready_o SHALL rise on the following edge.
REQ-022 If cfg_en_i is low in IDLE, bytes SHALL still be accepted into an empty holding register but no frame SHALL start; if cfg_en_i is deasserted mid-frame, the current frame SHALL complete.
REQ-023 busy_o SHALL equal (state != IDLE) OR (holding register full).
REQ-024 tx_o SHALL be driven from a flop (glitch-free).

Reset
REQ-025 While rst_i is high, tx_o SHALL be 1, data_ready_o 1, busy_o 0, the state IDLE, the counters 0 and the holding register empty.
REQ-026 Asserting rst_i mid-frame SHALL abort the frame at once; tx_o SHALL return high asynchronously and the held byte SHALL be discarded.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, parity SHALL follow cfg_parity_en_i per REQ-017/019.
REQ-028 When UART_TX_PARITY_EN is undefined, the PARITY state and parity logic SHALL be absent, cfg_parity_en_i SHALL be ignored, and frames SHALL never contain a parity bit.

Verification
REQ-029 div=4, 1 stop, no parity, send 0x55 -> tx_o low 1 cycle after accept, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high; frame = 40 cycles.
REQ-030 div=3, parity on (macro defined), send 0x07 -> parity bit 1, frame = 33 cycles; send 0x03 -> parity bit 0.
REQ-031 div=2, 2 stop bits, data_valid_i held high with 0xA5 then 0x3C -> second start bit directly after the 4 stop cycles, no gap; data_ready_o high 1 cycle after each START entry.
REQ-032 div=0 -> each bit lasts 1 cycle, identical to div=1.
REQ-033 Assert rst_i at the 3rd data bit with a byte held -> tx_o=1 immediately, data_ready_o=1, busy_o=0, no further frames after release.
REQ-034 cfg_en_i=0, send 0x81 -> accepted, data_ready_o=0, tx_o stays 1; raise cfg_en_i -> frame starts on the next edge.
